// File: rtl/rotation_sequencer.sv
// Staggered launch sequencer for the four swerve rotation angle controllers.
// Tracks per-wheel completion, stall and timeout; aborts launched wheels on error.
module rotation_sequencer #(
    parameter int unsigned STAGGER_CYCLES = 1000,
    parameter int unsigned MASK_CYCLES    = 8,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter int unsigned ABORT_HOLD     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [47:0] cmd_angles,
    input  logic [3:0]  cmd_mask,
    input  logic        user_abort,
    output logic [47:0] target_angle,
    output logic [3:0]  angle_update,
    output logic [3:0]  abort_angle,
    input  logic [3:0]  angle_done,
    input  logic [3:0]  stalled,
    output logic        busy,
    output logic        seq_done,
    output logic [1:0]  err_code,
    output logic [3:0]  err_wheel,
    output logic [3:0]  done_mask
);

    localparam int unsigned SW =
        (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam logic [SW-1:0] STAG_LD = SW'(STAGGER_CYCLES - 1);
    localparam logic [3:0]    MASK_LD = 4'(MASK_CYCLES);
    localparam logic [3:0]    HOLD_LD = 4'(ABORT_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ABORT,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [47:0]      target_q, target_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       launched_q, launched_d;
    logic [3:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic [3:0]       errw_q, errw_d;
    logic [SW-1:0]    stag_q, stag_d;
    logic [23:0]      tmo_q, tmo_d;
    logic [3:0]       hold_q, hold_d;
    logic [3:0][3:0]  mcnt_q, mcnt_d;

    logic [3:0][3:0]  mdec;
    logic [3:0]       sel;
    logic [3:0]       stall_hit;
    logic [3:0]       upd;
    logic [3:0]       abrt;
    logic [23:0]      tmo_inc;
    logic             fire;
    logic             active;
    logic             err_any;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            mask_q     <= '0;
            pending_q  <= '0;
            launched_q <= '0;
            done_q     <= '0;
            err_q      <= '0;
            errw_q     <= '0;
            stag_q     <= '0;
            tmo_q      <= '0;
            hold_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            launched_q <= launched_d;
            done_q     <= done_d;
            err_q      <= err_d;
            errw_q     <= errw_d;
            stag_q     <= stag_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            mcnt_q     <= mcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        mask_d     = mask_q;
        pending_d  = pending_q;
        launched_d = launched_q;
        done_d     = done_q;
        err_d      = err_q;
        errw_d     = errw_q;
        stag_d     = stag_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        mcnt_d     = mcnt_q;
        mdec       = '0;
        upd        = '0;
        abrt       = '0;

        // lowest pending wheel: ascending order, unmasked wheels cost nothing
        sel       = pending_q & (~pending_q + 4'd1);
        active    = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        fire      = (state_q == S_LAUNCH) && (stag_q == '0)
                    && (pending_q != '0);
        stall_hit = stalled & launched_q;
        tmo_inc   = tmo_q + 24'd1;
        err_any   = active && (user_abort || (stall_hit != '0)
                    || (tmo_inc == TIMEOUT_CYCLES));

        if (fire && !err_any) begin
            upd = sel;
        end

        if (active) begin
            tmo_d = tmo_inc;
            for (int i = 0; i < 4; i++) begin
                if (launched_q[i]) begin
                    mdec[i]   = (mcnt_q[i] == 4'd0) ? 4'd0
                                                    : mcnt_q[i] - 4'd1;
                    mcnt_d[i] = mdec[i];
                    if ((mdec[i] == 4'd0) && angle_done[i]) begin
                        done_d[i] = 1'b1;
                    end
                end
                if (upd[i]) begin
                    launched_d[i] = 1'b1;
                    mcnt_d[i]     = MASK_LD;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    target_d   = cmd_angles;
                    mask_d     = cmd_mask;
                    pending_d  = cmd_mask;
                    launched_d = '0;
                    done_d     = '0;
                    err_d      = '0;
                    errw_d     = '0;
                    stag_d     = '0;
                    tmo_d      = '0;
                    mcnt_d     = '0;
                    state_d    = (cmd_mask == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH, S_WAIT: begin
                if (err_any) begin
                    state_d = S_ABORT;
                    hold_d  = HOLD_LD;
                    if (user_abort) begin
                        err_d = 2'b11;
                    end else if (stall_hit != '0) begin
                        err_d  = 2'b01;
                        errw_d = stall_hit;
                    end else begin
                        err_d = 2'b10;
                    end
                end else if (state_q == S_LAUNCH) begin
                    if (fire) begin
                        pending_d = pending_q & ~sel;
                        stag_d    = STAG_LD;
                        if ((pending_q & ~sel) == '0) begin
                            state_d = S_WAIT;
                        end
                    end else if (stag_q != '0) begin
                        stag_d = stag_q - SW'(1);
                    end
                end else if (done_q == mask_q) begin
                    state_d = S_FINISH;
                end
            end
            S_ABORT: begin
                abrt = launched_q;
                if (hold_q == 4'd0) begin
                    state_d = S_FINISH;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign seq_done     = (state_q == S_FINISH);
    assign angle_update = upd;
    assign abort_angle  = abrt;
    assign target_angle = target_q;
    assign err_code     = err_q;
    assign err_wheel    = errw_q;
    assign done_mask    = done_q;

endmodule

// File: tb/tb_rotation_sequencer.sv
// Scoreboard bench for rotation_sequencer: stimulus pushes expected events,
// a monitor pops and compares launch pulses, abort runs and sequence ends.
module tb_rotation_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [47:0] cmd_angles = '0;
    logic [3:0]  cmd_mask = '0;
    logic        user_abort = 1'b0;
    logic [47:0] target_angle;
    logic [3:0]  angle_update;
    logic [3:0]  abort_angle;
    logic [3:0]  angle_done = '0;
    logic [3:0]  stalled = '0;
    logic        busy;
    logic        seq_done;
    logic [1:0]  err_code;
    logic [3:0]  err_wheel;
    logic [3:0]  done_mask;

    always #5 clock = ~clock;

    rotation_sequencer #(
        .STAGGER_CYCLES(10),
        .MASK_CYCLES(8),
        .TIMEOUT_CYCLES(24'd100),
        .ABORT_HOLD(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_angles(cmd_angles),
        .cmd_mask(cmd_mask),
        .user_abort(user_abort),
        .target_angle(target_angle),
        .angle_update(angle_update),
        .abort_angle(abort_angle),
        .angle_done(angle_done),
        .stalled(stalled),
        .busy(busy),
        .seq_done(seq_done),
        .err_code(err_code),
        .err_wheel(err_wheel),
        .done_mask(done_mask)
    );

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        int         len;
    } ab_t;

    typedef struct {
        int          cyc;
        logic [1:0]  err;
        logic [3:0]  ew;
        logic [3:0]  dm;
        logic [47:0] ta;
    } sq_t;

    ev_t upd_exp[$];
    ab_t ab_exp[$];
    sq_t sq_exp[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: samples 2ns after the inactive edge
    int         run = 0;
    int         rstart = 0;
    logic [3:0] rval = '0;

    initial begin : monitor
        ev_t e;
        ab_t a;
        sq_t s;
        forever begin
            @(negedge clock);
            #2;
            if (angle_update != 4'h0) begin
                if (upd_exp.size() == 0) begin
                    check("upd_unexpected", angle_update, 0);
                end else begin
                    e = upd_exp.pop_front();
                    check("upd_cyc", cyc, e.cyc);
                    check("upd_val", angle_update, e.val);
                end
            end
            if (abort_angle != 4'h0) begin
                if (run == 0) begin
                    rstart = cyc;
                    rval   = abort_angle;
                end
                run++;
            end else if (run > 0) begin
                if (ab_exp.size() == 0) begin
                    check("abort_unexpected", rval, 0);
                end else begin
                    a = ab_exp.pop_front();
                    check("abort_start", rstart, a.cyc);
                    check("abort_val", rval, a.val);
                    check("abort_len", run, a.len);
                end
                run = 0;
            end
            if (seq_done) begin
                if (sq_exp.size() == 0) begin
                    check("seq_unexpected", seq_done, 0);
                end else begin
                    s = sq_exp.pop_front();
                    check("seq_cyc", cyc, s.cyc);
                    check("seq_err", err_code, s.err);
                    check("seq_errw", err_wheel, s.ew);
                    check("seq_done_mask", done_mask, s.dm);
                    check("seq_target", target_angle, s.ta);
                end
            end
        end
    end

    task automatic issue(input logic [47:0] ang, input logic [3:0] m,
                         output int acc);
        @(negedge clock);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_angles = ang;
        cmd_mask   = m;
        acc        = cyc;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(negedge clock);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_end(input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            #3;
            got = seq_done;
        end
        if (!got) check("seq_done_bound", seq_done, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          a;
        logic [47:0] ang;

        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_upd", angle_update, 0);
        check("rst_abort", abort_angle, 0);
        check("rst_err", {err_code, err_wheel, done_mask}, 0);
        check("rst_target", target_angle, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // empty mask finishes straight away
        ang = {12'd7, 12'd6, 12'd5, 12'd4};
        issue(ang, 4'h0, a);
        sq_exp.push_back('{a + 1, 2'b00, 4'h0, 4'h0, ang});
        wait_end(5);

        // async reset while wheel 0 is launching
        angle_done = 4'hF;
        issue({4{12'd50}}, 4'hF, a);
        upd_exp.push_back('{a + 1, 4'b0001});
        step_to(a + 1);
        #4;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_upd", angle_update, 0);
        check("mid_rst_abort", abort_angle, 0);
        check("mid_rst_target", target_angle, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // all four wheels, already at target
        ang = {12'd400, 12'd300, 12'd200, 12'd100};
        issue(ang, 4'hF, a);
        upd_exp.push_back('{a + 1, 4'b0001});
        upd_exp.push_back('{a + 11, 4'b0010});
        upd_exp.push_back('{a + 21, 4'b0100});
        upd_exp.push_back('{a + 31, 4'b1000});
        sq_exp.push_back('{a + 41, 2'b00, 4'h0, 4'hF, ang});
        wait_end(60);

        // sparse mask: wheels 1 and 3 only
        ang = {12'd300, 12'd0, 12'd90, 12'd0};
        issue(ang, 4'b1010, a);
        upd_exp.push_back('{a + 1, 4'b0010});
        upd_exp.push_back('{a + 11, 4'b1000});
        sq_exp.push_back('{a + 21, 2'b00, 4'h0, 4'b1010, ang});
        wait_end(40);
        @(negedge clock);
        #3;
        check("hold_w1_angle", target_angle[23:12], 90);
        check("hold_w3_angle", target_angle[47:36], 300);
        check("hold_done_mask", done_mask, 4'b1010);
        check("idle_busy", busy, 0);

        // stall on wheel 1 before wheels 2,3 launch
        angle_done = 4'h0;
        ang = {12'd11, 12'd22, 12'd33, 12'd44};
        issue(ang, 4'hF, a);
        upd_exp.push_back('{a + 1, 4'b0001});
        upd_exp.push_back('{a + 11, 4'b0010});
        ab_exp.push_back('{a + 16, 4'b0011, 4});
        sq_exp.push_back('{a + 20, 2'b01, 4'b0010, 4'h0, ang});
        step_to(a + 15);
        stalled = 4'b0010;
        wait_end(30);
        stalled = 4'h0;

        // timeout with no wheel reaching target
        issue(ang, 4'hF, a);
        upd_exp.push_back('{a + 1, 4'b0001});
        upd_exp.push_back('{a + 11, 4'b0010});
        upd_exp.push_back('{a + 21, 4'b0100});
        upd_exp.push_back('{a + 31, 4'b1000});
        ab_exp.push_back('{a + 101, 4'hF, 4});
        sq_exp.push_back('{a + 105, 2'b10, 4'h0, 4'h0, ang});
        wait_end(130);

        // user abort beats a same-cycle stall in WAIT
        issue(ang, 4'b0001, a);
        upd_exp.push_back('{a + 1, 4'b0001});
        ab_exp.push_back('{a + 6, 4'b0001, 4});
        sq_exp.push_back('{a + 10, 2'b11, 4'h0, 4'h0, ang});
        step_to(a + 5);
        user_abort = 1'b1;
        stalled    = 4'b0001;
        wait_end(20);
        stalled = 4'h0;

        // user abort in IDLE does nothing
        repeat (3) @(negedge clock);
        #3;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_err_hold", err_code, 2'b11);
        user_abort = 1'b0;

        repeat (3) @(negedge clock);
        #3;
        check("upd_left", upd_exp.size(), 0);
        check("abort_left", ab_exp.size(), 0);
        check("seq_left", sq_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotation_sequencer.md
Name: rotation_sequencer

Overview:
Sequences angle moves for the four swerve rotation modules, each driven by its own PWM/PID angle controller. It accepts one 4-wheel angle command and launches the wheels one at a time with a programmable stagger to limit inrush current. It then tracks per-wheel completion, stall and timeout, and aborts the move cleanly on error or user request. It sits between the register/SPI command layer and the four angle controllers.

Parameters:
STAGGER_CYCLES, 1000, clock cycles between successive wheel launches (>=1)
MASK_CYCLES, 8, cycles after a wheel's launch during which its angle_done is ignored (1..15)
TIMEOUT_CYCLES, 24'd5000000, max cycles from command accept to all-done (24-bit)
ABORT_HOLD, 4, cycles abort_angle is held asserted (1..15)

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&cmd_ready
cmd_angles  in  48  {w3,w2,w1,w0}, 12-bit target angle each
cmd_mask  in  4  wheels participating in the command
user_abort  in  1  level; abort the current sequence
target_angle  out  48  angles captured at accept, held until next accept
angle_update  out  4  one-cycle launch pulse per wheel
abort_angle  out  4  abort to the launched wheels, held ABORT_HOLD cycles
angle_done  in  4  per-wheel at-target level from the angle controllers
stalled  in  4  per-wheel stall level from the angle controllers
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse when the sequence ends (success or error)
err_code  out  2  00 none, 01 stall, 10 timeout, 11 user abort
err_wheel  out  4  wheels with stalled=1 at the moment of stall error
done_mask  out  4  wheels launched and confirmed done

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE and all counters are 0.
- States: IDLE, LAUNCH, WAIT, ABORT, FINISH.
- IDLE, on accept:
  - Capture cmd_angles to target_angle and cmd_mask to an internal mask.
  - Clear err_code, err_wheel and done_mask.
  - Zero the timeout counter and go to LAUNCH.
  - If cmd_mask==0, go directly to FINISH instead; seq_done pulses 1 cycle after accept with err_code=00.
- LAUNCH:
  - Wheels launch in ascending index order; unmasked wheels are skipped at zero cost.
  - The first masked wheel's angle_update pulses on the cycle after accept.
  - Each subsequent masked wheel pulses exactly STAGGER_CYCLES cycles after the previous pulse.
  - After the last launch, go to WAIT.
- Completion tracking (runs in both LAUNCH and WAIT):
  - Each launched wheel has a 4-bit mask counter loaded with MASK_CYCLES on its launch.
  - When the counter reaches 0 and angle_done[i]=1, done_mask[i] sets and is sticky.
  - A wheel that is already at target therefore completes MASK_CYCLES+1 cycles after launch.
  - In WAIT, when done_mask equals the captured mask, go to FINISH with err_code=00.
- Timeout counter:
  - Increments every cycle in LAUNCH and WAIT.
  - Reaching TIMEOUT_CYCLES gives err_code=10 and goes to ABORT.
- Stall: stalled[i]=1 for any launched wheel i in LAUNCH or WAIT gives err_code=01, err_wheel=stalled & launched, then ABORT. Stall on an unlaunched wheel is ignored.
- User abort: user_abort=1 in LAUNCH or WAIT gives err_code=11, then ABORT. user_abort in IDLE is ignored.
- Same-cycle priority: user abort > stall > timeout > completion. An error on the same cycle that completion would be reached wins.
- ABORT:
  - abort_angle = launched-wheel set, held exactly ABORT_HOLD cycles.
  - No further angle_update pulses are issued.
  - Then go to FINISH.
- FINISH: seq_done=1 for one cycle, then IDLE. err_code, err_wheel and done_mask hold until the next accept.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately, and no abort pulse is issued.
- cmd_valid outside IDLE is ignored (no queueing).

Test Plan:
- STAGGER=10, MASK=8, mask=4'hF, angle_done stuck 1 -> angle_update pulses at accept+1, +11, +21, +31; seq_done at accept+41 (last launch + MASK + 1 to set done_mask + 1 WAIT→FINISH); err_code=00, done_mask=F.
- mask=4'b1010, angles {12'd300,0,12'd90,0} -> only angle_update[1] and angle_update[3] pulse, 10 cycles apart; target_angle[23:12]=90 and target_angle[47:36]=300 held after finish.
- stalled[1]=1 while wheel 3 is still unlaunched -> err_code=01, err_wheel=0010, abort_angle=0011 for 4 cycles, angle_update[3] never pulses, then seq_done.
- TIMEOUT_CYCLES=100, angle_done=0 -> abort at cycle 100 after accept, err_code=10, abort_angle=launched set, seq_done 5 cycles later.
- user_abort and stalled[0] asserted on the same cycle in WAIT -> err_code=11; mask=0 command -> seq_done at accept+1 with err_code=00.
- reset_n low mid-LAUNCH -> busy=0, cmd_ready=1, angle_update=0 immediately; a new command afterwards starts from wheel 0.
